// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM control unit: main FSM, ALU decoder, condition-gated write enables and a
// memory-wait timeout on the shared instruction/data memory port.
// Optional feature macro: ARM_MC_LINK_EN adds a BRLINK state so BL writes PC+4 to R14.
module arm_multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TIMEOUT_W      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       cond_ex,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemW,
  output logic       RegW,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] RegSrc,
  output logic [3:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       shRA1Control,
  output logic       carryOut_Control,
  output logic [3:0] state_o,
  output logic       mem_err
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StBrLink   = 4'd10
  } state_e;

  localparam bit TimeoutEn = (TIMEOUT_CYCLES > 0);
  // Guarded so a zero timeout never evaluates an underflowed constant.
  localparam logic [TIMEOUT_W-1:0] CntLast =
      TimeoutEn ? TIMEOUT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 mem_wait;
  logic                 timeout;
  logic                 arith;
  logic                 alu_reg_w;
  logic                 link_sel;

  // Wait detection: only the three memory-port states can stall on mem_ready.
  always_comb begin
    mem_wait = ((state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite)) &&
               !mem_ready;
    timeout  = TimeoutEn && mem_wait && (cnt_q == CntLast);
    cnt_d    = (mem_wait && !timeout) ? cnt_q + TIMEOUT_W'(1) : '0;
  end

  // Next-state sequencing; a timeout abandons the access and refetches.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:    if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? StExecI : StExecR;
          2'b01:   state_d = StMemAdr;
`ifdef ARM_MC_LINK_EN
          2'b10:   state_d = Funct[4] ? StBrLink : StBranch;
`else
          2'b10:   state_d = StBranch;
`endif
          default: state_d = StFetch;
        endcase
      end
      StMemAdr: begin
        if (!cond_ex)      state_d = StFetch;
        else if (Funct[0]) state_d = StMemRead;
        else               state_d = StMemWrite;
      end
      StMemRead:  if (mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (mem_ready) state_d = StFetch;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
`ifdef ARM_MC_LINK_EN
      StBrLink:   state_d = StBranch;
`endif
      default:    state_d = StFetch;
    endcase
    if (timeout) state_d = StFetch;
  end

  // State and wait-counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ALU decoder terms shared by the execute and ALU writeback states.
  always_comb begin
    case (Funct[4:1])
      4'b0010, 4'b0011, 4'b0100, 4'b0101,
      4'b0110, 4'b0111, 4'b1010, 4'b1011: arith = 1'b1;
      default:                            arith = 1'b0;
    endcase
    // TST/TEQ/CMP/CMN only update flags.
    alu_reg_w = cond_ex && (Funct[4:3] != 2'b10);
  end

  // Per-state control outputs; strobes forced low while reset is asserted.
  always_comb begin
    mem_req          = 1'b0;
    AdrSrc           = 1'b0;
    IRWrite          = 1'b0;
    PCWrite          = 1'b0;
    MemW             = 1'b0;
    RegW             = 1'b0;
    ResultSrc        = 2'b00;
    ALUSrcA          = 2'b00;
    ALUSrcB          = 2'b00;
    ALUControl       = 4'b0100;
    FlagW            = 2'b00;
    shRA1Control     = 1'b0;
    carryOut_Control = 1'b1;
    mem_err          = timeout;
    link_sel         = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      StMemAdr: begin
        ALUSrcB = 2'b01;
      end
      StMemRead: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      StMemWrite: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        MemW    = 1'b1;
      end
      StExecR, StExecI: begin
        ALUSrcB          = (state_q == StExecI) ? 2'b01 : 2'b00;
        ALUControl       = Funct[4:1];
        carryOut_Control = arith;
        shRA1Control     = (Funct[4:1] == 4'b1101);
      end
      StAluWb: begin
        ALUControl       = Funct[4:1];
        carryOut_Control = arith;
        shRA1Control     = (Funct[4:1] == 4'b1101);
        FlagW            = {Funct[0], Funct[0] & arith} & {2{cond_ex}};
        RegW             = alu_reg_w;
        PCWrite          = cond_ex && (Rd == 4'b1111) && alu_reg_w;
      end
      StBranch: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = cond_ex;
      end
`ifdef ARM_MC_LINK_EN
      StBrLink: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        RegW      = cond_ex;
        link_sel  = 1'b1;
      end
`endif
      default: ;
    endcase
    if (reset) begin
      mem_req = 1'b0;
      IRWrite = 1'b0;
      PCWrite = 1'b0;
      MemW    = 1'b0;
      RegW    = 1'b0;
      FlagW   = 2'b00;
      mem_err = 1'b0;
    end
  end

  assign ImmSrc  = Op;
  assign RegSrc  = {link_sel, (Op == 2'b10), (Op == 2'b01) & ~Funct[0]};
  assign state_o = state_q;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Scoreboard bench for arm_multicycle_ctrl: the driver pushes a hand-computed expectation per
// cycle, the monitor pops and compares on the falling edge.
module tb_arm_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'b0;
  logic [3:0] Rd = 4'b0;
  logic       cond_ex = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, AdrSrc, IRWrite, PCWrite, MemW, RegW;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, FlagW;
  logic [2:0] RegSrc;
  logic [3:0] ALUControl, state_o;
  logic       shRA1Control, carryOut_Control, mem_err;

  always #5 clk = ~clk;

  arm_multicycle_ctrl #(
    .TIMEOUT_CYCLES(16),
    .TIMEOUT_W     (5)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .Op              (Op),
    .Funct           (Funct),
    .Rd              (Rd),
    .cond_ex         (cond_ex),
    .mem_ready       (mem_ready),
    .mem_req         (mem_req),
    .AdrSrc          (AdrSrc),
    .IRWrite         (IRWrite),
    .PCWrite         (PCWrite),
    .MemW            (MemW),
    .RegW            (RegW),
    .ResultSrc       (ResultSrc),
    .ALUSrcA         (ALUSrcA),
    .ALUSrcB         (ALUSrcB),
    .ImmSrc          (ImmSrc),
    .RegSrc          (RegSrc),
    .ALUControl      (ALUControl),
    .FlagW           (FlagW),
    .shRA1Control    (shRA1Control),
    .carryOut_Control(carryOut_Control),
    .state_o         (state_o),
    .mem_err         (mem_err)
  );

  // States
  localparam logic [3:0] SF = 4'd0, SD = 4'd1, SMA = 4'd2, SMR = 4'd3, SMWB = 4'd4,
                         SMW = 4'd5, SER = 4'd6, SEI = 4'd7, SAWB = 4'd8, SBR = 4'd9,
                         SBL = 4'd10;
  // Strobes {mem_req, IRWrite, PCWrite, MemW, RegW, mem_err}
  localparam logic [5:0] K_NONE = 6'b000000, K_FREQ = 6'b100000, K_FDONE = 6'b111000,
                         K_RW = 6'b000010, K_PC = 6'b001000, K_RWPC = 6'b001010,
                         K_STW = 6'b100100, K_STERR = 6'b100101, K_FERR = 6'b100001;

  typedef struct {
    logic [3:0]  st;
    logic [5:0]  strb;
    bit          dp_en;
    logic [19:0] dp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  logic [1:0] i_op = 2'b00;
  logic [5:0] i_funct = 6'b0;
  logic [3:0] i_rd = 4'b0;

  // {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, FlagW, shRA1, carryOut}
  function automatic logic [19:0] mkdp(input logic adr, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] imm, input logic [2:0] rsrc,
                                       input logic [3:0] alu, input logic [1:0] fw,
                                       input logic sh, input logic co);
    return {adr, rs, sa, sb, imm, rsrc, alu, fw, sh, co};
  endfunction

  task automatic set_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
    i_op    = op;
    i_funct = funct;
    i_rd    = rd;
  endtask

  task automatic cyc(input logic rst, input logic rdy, input logic cnd, input logic [3:0] st,
                     input logic [5:0] strb, input string name, input bit dp_en = 1'b0,
                     input logic [19:0] dp = 20'b0);
    exp_t x;
    @(posedge clk);
    #1;
    reset     = rst;
    mem_ready = rdy;
    cond_ex   = cnd;
    Op        = i_op;
    Funct     = i_funct;
    Rd        = i_rd;
    x.st = st; x.strb = strb; x.dp_en = dp_en; x.dp = dp; x.name = name;
    sb_q.push_back(x);
  endtask

  // Monitor: compares each queued expectation against the settled outputs.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (state_o !== e.st) begin
        failures++;
        $display("FAIL %s state: got %0d want %0d", e.name, state_o, e.st);
      end
      checks++;
      if ({mem_req, IRWrite, PCWrite, MemW, RegW, mem_err} !== e.strb) begin
        failures++;
        $display("FAIL %s strobes: got %b want %b", e.name,
                 {mem_req, IRWrite, PCWrite, MemW, RegW, mem_err}, e.strb);
      end
      if (e.dp_en) begin
        checks++;
        if ({AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, FlagW,
             shRA1Control, carryOut_Control} !== e.dp) begin
          failures++;
          $display("FAIL %s datapath: got %b want %b", e.name,
                   {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, FlagW,
                    shRA1Control, carryOut_Control}, e.dp);
        end
      end
    end
  end

  initial begin
    // LDR, then reset in the middle of MEMREAD
    set_instr(2'b01, 6'b011001, 4'd2);
    cyc(0, 1, 1, SF, K_FDONE, "ldr0_fetch", 1,
        mkdp(0, 2'b10, 2'b01, 2'b10, 2'b01, 3'b000, 4'b0100, 2'b00, 0, 1));
    cyc(0, 0, 1, SD, K_NONE, "ldr0_decode");
    cyc(0, 0, 1, SMA, K_NONE, "ldr0_memadr", 1,
        mkdp(0, 2'b00, 2'b00, 2'b01, 2'b01, 3'b000, 4'b0100, 2'b00, 0, 1));
    cyc(0, 0, 1, SMR, K_FREQ, "ldr0_memread");
    cyc(1, 0, 1, SMR, K_NONE, "rst_cycle1");
    cyc(1, 0, 1, SF, K_NONE, "rst_cycle2", 1,
        mkdp(0, 2'b10, 2'b01, 2'b10, 2'b01, 3'b000, 4'b0100, 2'b00, 0, 1));
    cyc(0, 0, 1, SF, K_FREQ, "rst_release");
    // LDR with three wait cycles in MEMREAD
    cyc(0, 1, 1, SF, K_FDONE, "ldr1_fetch");
    cyc(0, 0, 1, SD, K_NONE, "ldr1_decode");
    cyc(0, 0, 1, SMA, K_NONE, "ldr1_memadr");
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 1, SMR, K_FREQ, "ldr1_wait", i == 0,
          mkdp(1, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 4'b0100, 2'b00, 0, 1));
    cyc(0, 1, 1, SMR, K_FREQ, "ldr1_done");
    cyc(0, 0, 1, SMWB, K_RW, "ldr1_memwb", 1,
        mkdp(0, 2'b01, 2'b00, 2'b00, 2'b01, 3'b000, 4'b0100, 2'b00, 0, 1));
    // ADD R1,R2,#5
    set_instr(2'b00, 6'b101000, 4'd1);
    cyc(0, 1, 1, SF, K_FDONE, "add_fetch");
    cyc(0, 0, 1, SD, K_NONE, "add_decode");
    cyc(0, 0, 1, SEI, K_NONE, "add_exec", 1,
        mkdp(0, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 4'b0100, 2'b00, 0, 1));
    cyc(0, 0, 1, SAWB, K_RW, "add_aluwb", 1,
        mkdp(0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0100, 2'b00, 0, 1));
    // CMP with S
    set_instr(2'b00, 6'b110101, 4'd0);
    cyc(0, 1, 1, SF, K_FDONE, "cmp_fetch");
    cyc(0, 0, 1, SD, K_NONE, "cmp_decode");
    cyc(0, 0, 1, SEI, K_NONE, "cmp_exec", 1,
        mkdp(0, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 4'b1010, 2'b00, 0, 1));
    cyc(0, 0, 1, SAWB, K_NONE, "cmp_aluwb", 1,
        mkdp(0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 4'b1010, 2'b11, 0, 1));
    // MOV PC,Rm (register form, writes R15)
    set_instr(2'b00, 6'b011010, 4'd15);
    cyc(0, 1, 1, SF, K_FDONE, "mov_fetch");
    cyc(0, 0, 1, SD, K_NONE, "mov_decode");
    cyc(0, 0, 1, SER, K_NONE, "mov_exec", 1,
        mkdp(0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 4'b1101, 2'b00, 1, 0));
    cyc(0, 0, 1, SAWB, K_RWPC, "mov_aluwb", 1,
        mkdp(0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 4'b1101, 2'b00, 1, 0));
    // ANDS with condition failed: no register or flag write
    set_instr(2'b00, 6'b000001, 4'd4);
    cyc(0, 1, 0, SF, K_FDONE, "ands_fetch");
    cyc(0, 0, 0, SD, K_NONE, "ands_decode");
    cyc(0, 0, 0, SER, K_NONE, "ands_exec");
    cyc(0, 0, 0, SAWB, K_NONE, "ands_aluwb", 1,
        mkdp(0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 2'b00, 0, 0));
    // STR that never completes: timeout in the 16th MEMWRITE cycle
    set_instr(2'b01, 6'b011000, 4'd3);
    cyc(0, 1, 1, SF, K_FDONE, "str_fetch");
    cyc(0, 0, 1, SD, K_NONE, "str_decode");
    cyc(0, 0, 1, SMA, K_NONE, "str_memadr");
    for (int i = 0; i < 15; i++)
      cyc(0, 0, 1, SMW, K_STW, "str_wait", i == 0,
          mkdp(1, 2'b00, 2'b00, 2'b00, 2'b01, 3'b001, 4'b0100, 2'b00, 0, 1));
    cyc(0, 0, 1, SMW, K_STERR, "str_timeout");
    // Undefined op: fetch with mem_ready arriving in the last allowed cycle
    set_instr(2'b11, 6'b000000, 4'd0);
    for (int i = 0; i < 15; i++) cyc(0, 0, 1, SF, K_FREQ, "fetch_wait");
    cyc(0, 1, 1, SF, K_FDONE, "fetch_late_ready");
    cyc(0, 0, 1, SD, K_NONE, "op11_decode");
    // Fetch that times out and refetches
    for (int i = 0; i < 15; i++) cyc(0, 0, 1, SF, K_FREQ, "fetch_wait2");
    cyc(0, 0, 1, SF, K_FERR, "fetch_timeout");
    // B, condition failed then passed
    set_instr(2'b10, 6'b100000, 4'd0);
    cyc(0, 1, 0, SF, K_FDONE, "b0_fetch");
    cyc(0, 0, 0, SD, K_NONE, "b0_decode", 1,
        mkdp(0, 2'b00, 2'b01, 2'b10, 2'b10, 3'b010, 4'b0100, 2'b00, 0, 1));
    cyc(0, 0, 0, SBR, K_NONE, "b0_branch", 1,
        mkdp(0, 2'b10, 2'b00, 2'b01, 2'b10, 3'b010, 4'b0100, 2'b00, 0, 1));
    cyc(0, 1, 1, SF, K_FDONE, "b1_fetch");
    cyc(0, 0, 1, SD, K_NONE, "b1_decode");
    cyc(0, 0, 1, SBR, K_PC, "b1_branch");
    // BL
    set_instr(2'b10, 6'b110000, 4'd0);
    cyc(0, 1, 1, SF, K_FDONE, "bl_fetch");
    cyc(0, 0, 1, SD, K_NONE, "bl_decode");
`ifdef ARM_MC_LINK_EN
    cyc(0, 0, 1, SBL, K_RW, "bl_brlink", 1,
        mkdp(0, 2'b10, 2'b01, 2'b10, 2'b10, 3'b110, 4'b0100, 2'b00, 0, 1));
`endif
    cyc(0, 0, 1, SBR, K_PC, "bl_branch", 1,
        mkdp(0, 2'b10, 2'b00, 2'b01, 2'b10, 3'b010, 4'b0100, 2'b00, 0, 1));
    cyc(0, 0, 1, SF, K_FREQ, "end_fetch");
    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
